// File: rtl/gps_uart_rx.sv
// 8N1 serial receiver for the GPS TX line: 16x oversampling, 3-sample majority vote,
// false-start rejection, framing-error and break handling.
module gps_uart_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_new,
    output logic       frame_err,
    output logic       busy
);
    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    samp_q, samp_d;
    logic [1:0]    vote_q, vote_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_new_q, rx_new_d;
    logic          frame_err_q, frame_err_d;

    logic counting, tick, decide, maj;

    assign counting = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign tick     = counting && (div_cnt_q == DIV_MAX);
    assign decide   = tick && (samp_q == 4'd9);
    // Third vote is the live sample on the deciding tick.
    assign maj      = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            samp_q      <= '0;
            vote_q      <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_new_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            samp_q      <= samp_d;
            vote_q      <= vote_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_new_q    <= rx_new_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        samp_d      = samp_q;
        vote_d      = vote_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_new_d    = 1'b0;
        frame_err_d = 1'b0;

        if (counting) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                samp_d = samp_q + 4'd1;
                if (samp_q == 4'd7) vote_d[0] = rx_s_q;
                if (samp_q == 4'd8) vote_d[1] = rx_s_q;
            end
        end

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                samp_d    = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (decide) begin
                    state_d   = maj ? IDLE : DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (decide) begin
                    shreg_d   = {maj, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop lets the next start edge resync immediately.
                if (decide) begin
                    if (maj) begin
                        rx_data_d = shreg_q;
                        rx_new_d  = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                div_cnt_d = '0;
                samp_d    = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_new    = rx_new_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_gps_uart_rx.sv
// Bench for gps_uart_rx: table-driven frames with a byte scoreboard, plus glitch,
// noise, framing-error/break and mid-frame reset sequences. 160 clk per bit.
module tb_gps_uart_rx;
    localparam int BIT_CLK = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_new;
    logic       frame_err;
    logic       busy;

    gps_uart_rx #(.CLK_HZ(1600000), .BAUD(10000)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .rx_new(rx_new), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int new_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // noise_bit >= 0 flips the line for 10 clk around sample 8 of that data bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input int noise_bit);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (noise_bit >= 0 && i == noise_bit + 1) begin
                clks(86);
                rx = ~bits[i];
                clks(10);
                rx = bits[i];
                clks(64);
            end else begin
                clks(BIT_CLK);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_new) begin
                new_cnt++;
                if (exp_q.size() == 0) check("unexpected_rx_new", 1, 0);
                else check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
            end
            if (frame_err) err_cnt++;
            if (rx_new && frame_err) check("rx_new_and_frame_err", 1, 0);
        end
    end

    typedef struct {
        logic [7:0] data;
        int         gap_bits;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n0, e0, waited;
        logic [9:0] bits;

        vecs[0] = '{8'hB5, 3, 8'hB5};
        vecs[1] = '{8'hB5, 0, 8'hB5};
        vecs[2] = '{8'h62, 0, 8'h62};
        vecs[3] = '{8'h01, 0, 8'h01};
        vecs[4] = '{8'h02, 3, 8'h02};

        clks(3);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_new", int'(rx_new), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        clks(2 * BIT_CLK);

        // single byte, then four back-to-back with zero gap
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(vecs[i].exp_data);
            send_frame(vecs[i].data, 1'b1, -1);
            if (vecs[i].gap_bits > 0) begin
                clks(vecs[i].gap_bits * BIT_CLK);
                check("queue_drained", exp_q.size(), 0);
                check("busy_after_frame", int'(busy), 0);
            end
        end
        check("rx_new_count_table", new_cnt, 5);
        check("frame_err_none_table", err_cnt, 0);

        // glitch: 40 clk low must be rejected as a false start
        n0 = new_cnt; e0 = err_cnt;
        rx = 1'b0;
        clks(40);
        rx = 1'b1;
        waited = 40;
        while (busy && waited < BIT_CLK) begin
            clks(1);
            waited++;
        end
        check("glitch_busy_drop", int'(busy), 0);
        clks(2 * BIT_CLK);
        check("glitch_no_rx_new", new_cnt, n0);
        check("glitch_no_frame_err", err_cnt, e0);

        // noise around sample 8 of data bit 2 is outvoted
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 2);
        clks(BIT_CLK);
        check("noise_rx_data", int'(rx_data), 8'h0F);
        check("noise_queue_drained", exp_q.size(), 0);

        // framing error followed by a held-low break
        n0 = new_cnt; e0 = err_cnt;
        send_frame(8'h55, 1'b0, -1);
        clks(3 * BIT_CLK);
        rx = 1'b1;
        clks(2 * BIT_CLK);
        check("framing_one_err", err_cnt, e0 + 1);
        check("framing_no_rx_new", new_cnt, n0);
        check("framing_rx_data_held", int'(rx_data), 8'h0F);
        check("framing_busy_idle", int'(busy), 0);
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, -1);
        clks(BIT_CLK);
        check("after_break_rx_data", int'(rx_data), 8'hA3);

        // reset during data bit 4 of 0x3C
        n0 = new_cnt; e0 = err_cnt;
        bits = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = bits[i];
            clks(BIT_CLK);
        end
        rx = bits[5];
        clks(80);
        check("busy_mid_frame", int'(busy), 1);
        rst = 1'b1;
        clks(1);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_busy", int'(busy), 0);
        rx = 1'b1;
        clks(5);
        rst = 1'b0;
        clks(2 * BIT_CLK);
        check("rst_no_rx_new", new_cnt, n0);
        check("rst_no_frame_err", err_cnt, e0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, -1);
        clks(BIT_CLK);
        check("after_rst_rx_data", int'(rx_data), 8'hC3);
        check("final_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
